base_arbiter: RTL and testbench
===============================

BASE_ARBITER -- requirements
Module: base_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: max cycles a granted transfer may wait for memory ack (1..255).
REQ-002 i_clk  input  1  clock; all state on rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 i_wb_ibus_adr  input  32; i_wb_ibus_cyc  input  1; o_wb_ibus_rdt  output  32; o_wb_ibus_ack  output  1: instruction requester, read-only.
REQ-005 i_wb_dbus_adr  input  32; i_wb_dbus_dat  input  32; i_wb_dbus_sel  input  4; i_wb_dbus_we  input  1; i_wb_dbus_cyc  input  1; o_wb_dbus_rdt  output  32; o_wb_dbus_ack  output  1: data requester.
REQ-006 i_wb_aux_adr  input  32; i_wb_aux_dat  input  32; i_wb_aux_sel  input  4; i_wb_aux_we  input  1; i_wb_aux_cyc  input  1; o_wb_aux_ack  output  1: auxiliary (collector write-back) requester; o_wb_aux_rdt  output  32.
REQ-007 o_wb_mem_adr  output  32; o_wb_mem_dat  output  32; o_wb_mem_sel  output  4; o_wb_mem_we  output  1; o_wb_mem_cyc  output  1; i_wb_mem_rdt  input  32; i_wb_mem_ack  input  1: shared memory port.
REQ-008 o_timeout  output  1: one-cycle pulse when a transfer is terminated by the watchdog.

Function
REQ-009 States IDLE and BUSY; reset state IDLE.
REQ-010 IDLE: if any cyc high, grant one requester this cycle, enter BUSY next cycle; grant held in a register for the whole transfer.
REQ-011 Arbitration round-robin over order ibus, dbus, aux, starting from the requester after the last granted one; after reset the start point is ibus.
REQ-012 BUSY: o_wb_mem_* = granted requester's adr/dat/sel/we with o_wb_mem_cyc = granted cyc; ibus grant drives we=0, sel=4'hF, dat=0.
REQ-013 IDLE: o_wb_mem_cyc=0; other mem outputs 0.
REQ-014 On i_wb_mem_ack in BUSY: assert granted requester's ack combinationally the same cycle, rdt = i_wb_mem_rdt; return to IDLE next cycle; last-grant pointer updated.
REQ-015 Non-granted requesters' ack SHALL be 0; all o_*_rdt SHALL carry i_wb_mem_rdt (ack qualifies).
REQ-016 i_wb_mem_ack while IDLE SHALL be ignored.
REQ-017 Granted requester drops cyc before ack: abort, no ack, return to IDLE next cycle, pointer updated as if completed.
REQ-018 Watchdog: 8-bit counter cleared on entering BUSY, increments each BUSY cycle without ack; reaching TIMEOUT: ack to granted requester with rdt 32'h0, o_timeout pulse, o_wb_mem_cyc dropped, return to IDLE.
REQ-019 Ack and timeout in the same cycle: normal ack wins, no o_timeout.
REQ-020 Minimum occupancy: one grant cycle plus memory latency; back-to-back requests from one requester SHALL yield at least one IDLE cycle between transfers.
REQ-021 Sustained requests from all three SHALL be served in strict rotation; no requester waits more than two completed transfers.

Reset
REQ-022 Asynchronous assertion on i_rst_n low: state IDLE, pointer to ibus-first, counter 0, all acks, o_wb_mem_cyc, o_timeout 0; synchronous release.
REQ-023 Reset mid-transfer: transfer dropped with no ack; requester re-arbitrates after release.

Structure
REQ-024 State encoding, requester index constants (IBUS=0, DBUS=1, AUX=2) in shared package base_pkg.
REQ-025 One sub-module, base_rr_pick: combinational 3-way round-robin picker (req vector, last grant -> grant one-hot).

Verification
REQ-026 Single ibus read adr 0x100, mem ack after 1 cycle, rdt 0xDEADBEEF -> ibus ack one cycle, rdt 0xDEADBEEF, mem we=0 sel=F.
REQ-027 ibus, dbus, aux all cyc held continuously -> grant order ibus, dbus, aux, ibus; each ack exactly once per transfer.
REQ-028 dbus write adr 0x40 dat 0x12345678 sel 4'b0011 -> mem port shows identical values, we=1, during BUSY only.
REQ-029 Memory never acks, TIMEOUT=4 -> requester ack with rdt 0 after 4 BUSY cycles, o_timeout pulses once, state IDLE.
REQ-030 aux drops cyc mid-BUSY -> no ack, IDLE next cycle, next pending dbus granted.
REQ-031 i_rst_n low during BUSY -> mem cyc and all acks 0 immediately, no ack after release until new arbitration.

Source files
------------

// File: rtl/base_pkg.sv
// Shared definitions for the base_arbiter slice: FSM encoding, requester
// indices, the forwarded bus record and the grant-to-index helper.
package base_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [1:0] IBUS = 2'd0;
    localparam logic [1:0] DBUS = 2'd1;
    localparam logic [1:0] AUX  = 2'd2;

    localparam int unsigned N_REQ    = 3;
    localparam logic [7:0]  WDOG_MAX = 8'hFF;

    typedef struct packed {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
    } wb_fwd_t;

    // An empty or corrupt grant maps to AUX so the next search restarts at ibus.
    function automatic logic [1:0] gnt_to_idx(input logic [2:0] gnt);
        logic [1:0] idx;
        case (gnt)
            3'b001:  idx = IBUS;
            3'b010:  idx = DBUS;
            3'b100:  idx = AUX;
            default: idx = AUX;
        endcase
        return idx;
    endfunction

endpackage

// File: rtl/base_arbiter_if.sv
// Bus bundle between three wishbone requesters, the shared memory port and
// the arbiter. The arbiter uses the slave view, the environment the master view.
interface base_arbiter_if;

    logic [31:0] i_wb_ibus_adr;
    logic        i_wb_ibus_cyc;
    logic [31:0] o_wb_ibus_rdt;
    logic        o_wb_ibus_ack;

    logic [31:0] i_wb_dbus_adr;
    logic [31:0] i_wb_dbus_dat;
    logic [3:0]  i_wb_dbus_sel;
    logic        i_wb_dbus_we;
    logic        i_wb_dbus_cyc;
    logic [31:0] o_wb_dbus_rdt;
    logic        o_wb_dbus_ack;

    logic [31:0] i_wb_aux_adr;
    logic [31:0] i_wb_aux_dat;
    logic [3:0]  i_wb_aux_sel;
    logic        i_wb_aux_we;
    logic        i_wb_aux_cyc;
    logic [31:0] o_wb_aux_rdt;
    logic        o_wb_aux_ack;

    logic [31:0] o_wb_mem_adr;
    logic [31:0] o_wb_mem_dat;
    logic [3:0]  o_wb_mem_sel;
    logic        o_wb_mem_we;
    logic        o_wb_mem_cyc;
    logic [31:0] i_wb_mem_rdt;
    logic        i_wb_mem_ack;

    modport slave (
        input  i_wb_ibus_adr, i_wb_ibus_cyc,
        output o_wb_ibus_rdt, o_wb_ibus_ack,
        input  i_wb_dbus_adr, i_wb_dbus_dat, i_wb_dbus_sel, i_wb_dbus_we, i_wb_dbus_cyc,
        output o_wb_dbus_rdt, o_wb_dbus_ack,
        input  i_wb_aux_adr, i_wb_aux_dat, i_wb_aux_sel, i_wb_aux_we, i_wb_aux_cyc,
        output o_wb_aux_rdt, o_wb_aux_ack,
        output o_wb_mem_adr, o_wb_mem_dat, o_wb_mem_sel, o_wb_mem_we, o_wb_mem_cyc,
        input  i_wb_mem_rdt, i_wb_mem_ack
    );

    modport master (
        output i_wb_ibus_adr, i_wb_ibus_cyc,
        input  o_wb_ibus_rdt, o_wb_ibus_ack,
        output i_wb_dbus_adr, i_wb_dbus_dat, i_wb_dbus_sel, i_wb_dbus_we, i_wb_dbus_cyc,
        input  o_wb_dbus_rdt, o_wb_dbus_ack,
        output i_wb_aux_adr, i_wb_aux_dat, i_wb_aux_sel, i_wb_aux_we, i_wb_aux_cyc,
        input  o_wb_aux_rdt, o_wb_aux_ack,
        input  o_wb_mem_adr, o_wb_mem_dat, o_wb_mem_sel, o_wb_mem_we, o_wb_mem_cyc,
        output i_wb_mem_rdt, i_wb_mem_ack
    );

endinterface

// File: rtl/base_rr_pick.sv
// Combinational 3-way round-robin picker: the search starts at the requester
// after the last winner and wraps in the order ibus, dbus, aux.
module base_rr_pick
    import base_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       last,
    output logic [N_REQ-1:0] gnt
);

    // Rotated priority chain selected by the previous winner.
    always_comb begin
        gnt = 3'b000;
        case (last)
            IBUS: begin
                if (req[DBUS]) begin
                    gnt = 3'b010;
                end else if (req[AUX]) begin
                    gnt = 3'b100;
                end else if (req[IBUS]) begin
                    gnt = 3'b001;
                end else begin
                    gnt = 3'b000;
                end
            end
            DBUS: begin
                if (req[AUX]) begin
                    gnt = 3'b100;
                end else if (req[IBUS]) begin
                    gnt = 3'b001;
                end else if (req[DBUS]) begin
                    gnt = 3'b010;
                end else begin
                    gnt = 3'b000;
                end
            end
            default: begin
                if (req[IBUS]) begin
                    gnt = 3'b001;
                end else if (req[DBUS]) begin
                    gnt = 3'b010;
                end else if (req[AUX]) begin
                    gnt = 3'b100;
                end else begin
                    gnt = 3'b000;
                end
            end
        endcase
    end

endmodule

// File: rtl/base_arbiter.sv
// Three-requester wishbone arbiter onto one memory port: round-robin grant in
// IDLE, transfer held in BUSY until memory ack, requester abort or watchdog expiry.
module base_arbiter
    import base_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    base_arbiter_if.slave bus,
    output logic          o_timeout
);

    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

    logic [0:0]  state_r;
    logic [2:0]  grant_r;
    logic [1:0]  last_r;
    logic [7:0]  wdog_r;

    logic [2:0]  req_s;
    logic [2:0]  pick_s;
    logic        busy_s;
    logic        gcyc_s;
    logic        abort_s;
    logic        ack_hit_s;
    logic        tmo_s;
    logic        done_s;
    logic        end_s;
    wb_fwd_t     fwd_s;
    logic [31:0] rdt_s;

    assign req_s = {bus.i_wb_aux_cyc, bus.i_wb_dbus_cyc, bus.i_wb_ibus_cyc};

    base_rr_pick u_pick (
        .req  (req_s),
        .last (last_r),
        .gnt  (pick_s)
    );

    // Termination decode; the watchdog fires once the counter has reached the
    // limit, and a memory ack in that same cycle still wins over the watchdog.
    always_comb begin
        busy_s    = (state_r == ST_BUSY);
        gcyc_s    = busy_s && ((grant_r & req_s) != 3'b000);
        abort_s   = busy_s && !gcyc_s;
        ack_hit_s = gcyc_s && bus.i_wb_mem_ack;
        tmo_s     = gcyc_s && !bus.i_wb_mem_ack && (wdog_r == TMO_LIMIT);
        done_s    = ack_hit_s || tmo_s;
        end_s     = done_s || abort_s;
    end

    // Route the granted requester onto the memory port; ibus is read-only.
    always_comb begin
        fwd_s = '{adr: 32'h0000_0000, dat: 32'h0000_0000, sel: 4'h0, we: 1'b0};
        if (busy_s) begin
            case (grant_r)
                3'b001: fwd_s = '{adr: bus.i_wb_ibus_adr, dat: 32'h0000_0000,
                                  sel: 4'hF, we: 1'b0};
                3'b010: fwd_s = '{adr: bus.i_wb_dbus_adr, dat: bus.i_wb_dbus_dat,
                                  sel: bus.i_wb_dbus_sel, we: bus.i_wb_dbus_we};
                3'b100: fwd_s = '{adr: bus.i_wb_aux_adr, dat: bus.i_wb_aux_dat,
                                  sel: bus.i_wb_aux_sel, we: bus.i_wb_aux_we};
                default: fwd_s = '{adr: 32'h0000_0000, dat: 32'h0000_0000, sel: 4'h0, we: 1'b0};
            endcase
        end else begin
            fwd_s = '{adr: 32'h0000_0000, dat: 32'h0000_0000, sel: 4'h0, we: 1'b0};
        end
    end

    assign rdt_s = tmo_s ? 32'h0000_0000 : bus.i_wb_mem_rdt;

    assign bus.o_wb_mem_adr  = fwd_s.adr;
    assign bus.o_wb_mem_dat  = fwd_s.dat;
    assign bus.o_wb_mem_sel  = fwd_s.sel;
    assign bus.o_wb_mem_we   = fwd_s.we;
    assign bus.o_wb_mem_cyc  = gcyc_s && !tmo_s;

    assign bus.o_wb_ibus_ack = done_s && grant_r[IBUS];
    assign bus.o_wb_dbus_ack = done_s && grant_r[DBUS];
    assign bus.o_wb_aux_ack  = done_s && grant_r[AUX];
    assign bus.o_wb_ibus_rdt = rdt_s;
    assign bus.o_wb_dbus_rdt = rdt_s;
    assign bus.o_wb_aux_rdt  = rdt_s;

    assign o_timeout = tmo_s;

    // Arbitration FSM, held grant, rotation pointer and watchdog counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
            grant_r <= 3'b000;
            last_r  <= AUX;
            wdog_r  <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_s != 3'b000) begin
                        state_r <= ST_BUSY;
                        grant_r <= pick_s;
                        wdog_r  <= 8'h00;
                    end else begin
                        grant_r <= 3'b000;
                    end
                end
                ST_BUSY: begin
                    if (end_s) begin
                        state_r <= ST_IDLE;
                        grant_r <= 3'b000;
                        last_r  <= gnt_to_idx(grant_r);
                    end else if (wdog_r != WDOG_MAX) begin
                        wdog_r <= wdog_r + 8'd1;
                    end else begin
                        wdog_r <= wdog_r;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    grant_r <= 3'b000;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_base_arbiter.sv
// Self-checking bench for base_arbiter: directed vector table, multi-cycle
// corner sequences and a randomized run against a cycle-level reference model.
module tb_base_arbiter;

    localparam int unsigned TMO = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic timeout;
    int   checks = 0;
    int   errors = 0;

    base_arbiter_if bif();

    base_arbiter #(.TIMEOUT(TMO)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .bus       (bif.slave),
        .o_timeout (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          who;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        we;
        int          lat;
        logic [31:0] rdt;
        logic [31:0] x_dat;
        logic [3:0]  x_sel;
        logic        x_we;
        logic [31:0] x_rdt;
        int          x_cyc;
        logic        x_tmo;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] acks();
        return {bif.o_wb_aux_ack, bif.o_wb_dbus_ack, bif.o_wb_ibus_ack};
    endfunction

    function automatic logic [31:0] rdt_of(input int who);
        case (who)
            0:       return bif.o_wb_ibus_rdt;
            1:       return bif.o_wb_dbus_rdt;
            default: return bif.o_wb_aux_rdt;
        endcase
    endfunction

    task automatic drive_req(input int who, input logic cyc, input logic [31:0] adr,
                             input logic [31:0] dat, input logic [3:0] sel, input logic we);
        case (who)
            0: begin
                bif.i_wb_ibus_cyc = cyc;
                bif.i_wb_ibus_adr = adr;
            end
            1: begin
                bif.i_wb_dbus_cyc = cyc;
                bif.i_wb_dbus_adr = adr;
                bif.i_wb_dbus_dat = dat;
                bif.i_wb_dbus_sel = sel;
                bif.i_wb_dbus_we  = we;
            end
            default: begin
                bif.i_wb_aux_cyc = cyc;
                bif.i_wb_aux_adr = adr;
                bif.i_wb_aux_dat = dat;
                bif.i_wb_aux_sel = sel;
                bif.i_wb_aux_we  = we;
            end
        endcase
    endtask

    task automatic clear_inputs();
        for (int r = 0; r < 3; r++) drive_req(r, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        bif.i_wb_mem_ack = 1'b0;
        bif.i_wb_mem_rdt = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {acks(), bif.o_wb_mem_cyc, timeout}, 5'b0);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic run_vec(input int k);
        vec_t        v;
        int          got;
        logic [2:0]  got_ack;
        logic [31:0] got_rdt;
        logic        got_tmo;
        v = vecs[k];
        got = -1;
        got_ack = 3'b000;
        got_rdt = 32'h0;
        got_tmo = 1'b0;
        for (int c = 0; c < 12 && got < 0; c++) begin
            drive_req(v.who, 1'b1, v.adr, v.dat, v.sel, v.we);
            bif.i_wb_mem_rdt = v.rdt;
            bif.i_wb_mem_ack = (v.lat >= 0 && c == v.lat + 1);
            @(negedge clk);
            if (c == 0)
                check($sformatf("vec%0d_grant_cycle_idle", k),
                      {bif.o_wb_mem_cyc, bif.o_wb_mem_adr}, 33'h0);
            if (c == 1)
                check($sformatf("vec%0d_mem_fields", k),
                      {bif.o_wb_mem_cyc, bif.o_wb_mem_adr, bif.o_wb_mem_dat,
                       bif.o_wb_mem_sel, bif.o_wb_mem_we},
                      {1'b1, v.adr, v.x_dat, v.x_sel, v.x_we});
            if (acks() != 3'b000) begin
                got     = c;
                got_ack = acks();
                got_rdt = rdt_of(v.who);
                got_tmo = timeout;
            end
            tick();
        end
        check($sformatf("vec%0d_ack_cycle", k), got, v.x_cyc);
        check($sformatf("vec%0d_ack_who", k), got_ack, 3'b001 << v.who);
        check($sformatf("vec%0d_rdt", k), got_rdt, v.x_rdt);
        check($sformatf("vec%0d_timeout", k), got_tmo, v.x_tmo);
        drive_req(v.who, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
        bif.i_wb_mem_ack = 1'b0;
        @(negedge clk);
        check($sformatf("vec%0d_after_idle", k), {acks(), bif.o_wb_mem_cyc, timeout}, 5'b0);
        tick();
    endtask

    task automatic run_rotation();
        logic [2:0] order[$];
        int         last_cyc;
        last_cyc = -1;
        do_reset();
        drive_req(0, 1'b1, 32'h1000, 32'h0, 4'h0, 1'b0);
        drive_req(1, 1'b1, 32'h2000, 32'h1, 4'h1, 1'b1);
        drive_req(2, 1'b1, 32'h3000, 32'h2, 4'h2, 1'b0);
        bif.i_wb_mem_ack = 1'b1;
        bif.i_wb_mem_rdt = 32'h5555_0000;
        for (int c = 0; c < 16 && order.size() < 4; c++) begin
            @(negedge clk);
            if (acks() != 3'b000) begin
                order.push_back(acks());
                last_cyc = c;
            end
            tick();
        end
        for (int i = 0; i < 4; i++)
            check($sformatf("rotation_%0d", i), (order.size() > i) ? order[i] : 3'b000,
                  (i == 1) ? 3'b010 : (i == 2) ? 3'b100 : 3'b001);
        check("rotation_fourth_ack_cycle", last_cyc, 7);
        clear_inputs();
        tick();
    endtask

    task automatic run_abort();
        do_reset();
        drive_req(2, 1'b1, 32'h700, 32'h7, 4'h7, 1'b1);
        @(negedge clk);
        tick();
        drive_req(2, 1'b0, 32'h700, 32'h7, 4'h7, 1'b1);
        drive_req(1, 1'b1, 32'h44, 32'h4, 4'hF, 1'b0);
        @(negedge clk);
        check("abort_no_ack", {acks(), bif.o_wb_mem_cyc, timeout}, 5'b0);
        tick();
        @(negedge clk);
        check("abort_then_idle", {acks(), bif.o_wb_mem_cyc}, 4'b0);
        tick();
        bif.i_wb_mem_ack = 1'b1;
        bif.i_wb_mem_rdt = 32'h0000_600D;
        @(negedge clk);
        check("abort_next_dbus", {acks(), bif.o_wb_mem_cyc, bif.o_wb_mem_adr, bif.o_wb_dbus_rdt},
              {3'b010, 1'b1, 32'h44, 32'h0000_600D});
        clear_inputs();
        tick();
    endtask

    task automatic run_reset_mid();
        do_reset();
        drive_req(0, 1'b1, 32'h500, 32'h0, 4'h0, 1'b0);
        @(negedge clk);
        tick();
        @(negedge clk);
        check("pre_reset_busy", {bif.o_wb_mem_cyc, bif.o_wb_mem_adr}, {1'b1, 32'h500});
        #2;
        bif.i_wb_mem_ack = 1'b1;
        rst_n = 1'b0;
        #1;
        check("reset_async_drop", {acks(), bif.o_wb_mem_cyc, timeout}, 5'b0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_reset_idle", {acks(), bif.o_wb_mem_cyc}, 4'b0);
        tick();
        @(negedge clk);
        check("post_reset_regrant", acks(), 3'b001);
        clear_inputs();
        tick();
    endtask

    task automatic run_random(input int n);
        logic        want[3];
        logic [31:0] r_adr[3];
        logic [31:0] r_dat[3];
        logic [3:0]  r_sel[3];
        logic        r_we[3];
        logic [2:0]  e_ack;
        logic [2:0]  prev_ack;
        logic        e_tmo, e_cyc, e_we, mem_ack;
        logic [3:0]  e_sel;
        logic [31:0] e_adr, e_dat, e_rdt, mem_rdt;
        logic [169:0] exp_v, act_v;
        bit          m_busy;
        int          m_owner, m_last, m_wait, o;
        do_reset();
        m_busy = 1'b0; m_owner = 0; m_last = 2; m_wait = 0; prev_ack = 3'b000;
        for (int r = 0; r < 3; r++) want[r] = 1'b0;
        for (int i = 0; i < n; i++) begin
            for (int r = 0; r < 3; r++) begin
                if (prev_ack[r]) want[r] = ($urandom_range(0, 1) == 1);
                else if (want[r]) want[r] = ($urandom_range(0, 99) >= 3);
                else want[r] = ($urandom_range(0, 99) < 30);
                r_adr[r] = $urandom;
                r_dat[r] = $urandom;
                r_sel[r] = 4'($urandom_range(0, 15));
                r_we[r]  = ($urandom_range(0, 1) == 1);
                drive_req(r, want[r], r_adr[r], r_dat[r], r_sel[r], r_we[r]);
            end
            mem_ack = ($urandom_range(0, 9) < 3);
            mem_rdt = $urandom;
            bif.i_wb_mem_ack = mem_ack;
            bif.i_wb_mem_rdt = mem_rdt;
            @(negedge clk);
            e_ack = 3'b000; e_tmo = 1'b0; e_cyc = 1'b0; e_we = 1'b0;
            e_sel = 4'h0; e_adr = 32'h0; e_dat = 32'h0; e_rdt = mem_rdt;
            if (m_busy) begin
                o = m_owner;
                e_adr = r_adr[o];
                e_dat = (o == 0) ? 32'h0 : r_dat[o];
                e_sel = (o == 0) ? 4'hF : r_sel[o];
                e_we  = (o == 0) ? 1'b0 : r_we[o];
                if (!want[o]) begin
                    m_busy = 1'b0; m_last = o;
                end else if (mem_ack) begin
                    e_ack[o] = 1'b1; e_cyc = 1'b1; m_busy = 1'b0; m_last = o;
                end else if (m_wait == TMO) begin
                    e_ack[o] = 1'b1; e_tmo = 1'b1; e_rdt = 32'h0; m_busy = 1'b0; m_last = o;
                end else begin
                    e_cyc = 1'b1; m_wait++;
                end
            end else if (want[0] || want[1] || want[2]) begin
                m_busy = 1'b1; m_wait = 0; m_owner = -1;
                for (int k = 1; k <= 3; k++)
                    if (m_owner < 0 && want[(m_last + k) % 3]) m_owner = (m_last + k) % 3;
            end
            exp_v = {e_ack, e_tmo, e_cyc, e_we, e_sel, e_adr, e_dat, e_rdt, e_rdt, e_rdt};
            act_v = {acks(), timeout, bif.o_wb_mem_cyc, bif.o_wb_mem_we, bif.o_wb_mem_sel,
                     bif.o_wb_mem_adr, bif.o_wb_mem_dat, bif.o_wb_ibus_rdt,
                     bif.o_wb_dbus_rdt, bif.o_wb_aux_rdt};
            check($sformatf("random_cycle_%0d", i), act_v, exp_v);
            prev_ack = e_ack;
            tick();
        end
        clear_inputs();
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: got expired want finished");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{0, 32'h100, 32'h55AA55AA, 4'h3, 1'b0, 1, 32'hDEADBEEF,
                    32'h0, 4'hF, 1'b0, 32'hDEADBEEF, 2, 1'b0};
        vecs[1] = '{1, 32'h40, 32'h12345678, 4'b0011, 1'b1, 0, 32'h00001111,
                    32'h12345678, 4'b0011, 1'b1, 32'h00001111, 1, 1'b0};
        vecs[2] = '{2, 32'h200, 32'hA5A5A5A5, 4'hC, 1'b0, 2, 32'hCAFEF00D,
                    32'hA5A5A5A5, 4'hC, 1'b0, 32'hCAFEF00D, 3, 1'b0};
        vecs[3] = '{0, 32'h104, 32'h0, 4'h0, 1'b0, 3, 32'h01020304,
                    32'h0, 4'hF, 1'b0, 32'h01020304, 4, 1'b0};
        vecs[4] = '{1, 32'h80, 32'h1, 4'hF, 1'b0, -1, 32'h77777777,
                    32'h1, 4'hF, 1'b0, 32'h0, 5, 1'b1};
        vecs[5] = '{2, 32'h300, 32'h9, 4'h1, 1'b1, 4, 32'h0BADC0DE,
                    32'h9, 4'h1, 1'b1, 32'h0BADC0DE, 5, 1'b0};

        do_reset();
        for (int k = 0; k < 6; k++) run_vec(k);

        bif.i_wb_mem_ack = 1'b1;
        bif.i_wb_mem_rdt = 32'h1234ABCD;
        @(negedge clk);
        check("idle_mem_ack_ignored", {acks(), bif.o_wb_mem_cyc, timeout, bif.o_wb_ibus_rdt},
              {5'b0, 32'h1234ABCD});
        clear_inputs();
        tick();

        run_rotation();
        run_abort();
        run_reset_mid();
        run_random(3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
